// File: rtl/ysyx_23060124_wbu_pkg.sv
// Shared definitions for the write-back/commit stage: FSM encoding, trap CSR
// addresses and the ecall cause code.
package ysyx_23060124_wbu_pkg;

    localparam int WBU_XLEN  = 32;
    localparam int WBU_CNT_W = 64;

    localparam logic [11:0] CSR_MEPC   = 12'h341;
    localparam logic [11:0] CSR_MCAUSE = 12'h342;
    localparam logic [31:0] MCAUSE_ECM = 32'd11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_COMMIT = 2'd1,
        ST_TRAP   = 2'd2,
        ST_REDIR  = 2'd3
    } wbu_state_e;

    // Any control-flow change other than ecall, which goes through the trap path.
    function automatic logic is_redirect(input logic brch, input logic taken,
                                         input logic jal, input logic jalr,
                                         input logic mret);
        return (brch & taken) | jal | jalr | mret;
    endfunction

endpackage

// File: rtl/ysyx_23060124_wbu_if.sv
// EXU->WBU instruction bus, GPR/CSR write ports, IFU redirect handshake and
// retire reporting, bundled for the commit stage.
interface ysyx_23060124_wbu_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 64
);
    logic             i_valid;
    logic             o_ready;
    logic [XLEN-1:0]  i_pc;
    logic [XLEN-1:0]  i_pc_next;
    logic [XLEN-1:0]  i_res;
    logic [4:0]       i_rd_addr;
    logic             i_wen;
    logic [11:0]      i_csr_addr;
    logic             i_csr_wen;
    logic             i_brch;
    logic             i_jal;
    logic             i_jalr;
    logic             i_mret;
    logic             i_ecall;
    logic [XLEN-1:0]  i_mepc;
    logic [XLEN-1:0]  i_mtvec;
    logic             o_rf_wen;
    logic [4:0]       o_rf_waddr;
    logic [XLEN-1:0]  o_rf_wdata;
    logic             o_csr_wen;
    logic [11:0]      o_csr_waddr;
    logic [XLEN-1:0]  o_csr_wdata;
    logic             o_redir_vld;
    logic [XLEN-1:0]  o_redir_pc;
    logic             i_redir_rdy;
    logic             o_retire;
    logic [CNT_W-1:0] o_retire_cnt;

    // The write-back stage itself.
    modport slave (
        input  i_valid, i_pc, i_pc_next, i_res, i_rd_addr, i_wen,
               i_csr_addr, i_csr_wen, i_brch, i_jal, i_jalr, i_mret, i_ecall,
               i_mepc, i_mtvec, i_redir_rdy,
        output o_ready, o_rf_wen, o_rf_waddr, o_rf_wdata, o_csr_wen,
               o_csr_waddr, o_csr_wdata, o_redir_vld, o_redir_pc,
               o_retire, o_retire_cnt
    );

    // The surrounding pipeline (EXU, register files, IFU).
    modport master (
        output i_valid, i_pc, i_pc_next, i_res, i_rd_addr, i_wen,
               i_csr_addr, i_csr_wen, i_brch, i_jal, i_jalr, i_mret, i_ecall,
               i_mepc, i_mtvec, i_redir_rdy,
        input  o_ready, o_rf_wen, o_rf_waddr, o_rf_wdata, o_csr_wen,
               o_csr_waddr, o_csr_wdata, o_redir_vld, o_redir_pc,
               o_retire, o_retire_cnt
    );

endinterface

// File: rtl/ysyx_23060124_wbu.sv
// Write-back/commit stage: writes GPR/CSRs, sequences ecall traps, redirects
// the IFU and counts retired instructions.
module ysyx_23060124_wbu #(
    parameter int              XLEN       = 32,
    parameter int              CNT_W      = 64,
    parameter logic [XLEN-1:0] MCAUSE_ECM = XLEN'(ysyx_23060124_wbu_pkg::MCAUSE_ECM)
) (
    input  logic                    clock,
    input  logic                    reset,
    ysyx_23060124_wbu_if.slave      bus
);
    import ysyx_23060124_wbu_pkg::*;

    wbu_state_e state_reg, state_next;

    logic [XLEN-1:0] pc_reg, tgt_reg, res_reg, mepc_reg, mtvec_reg;
    logic [4:0]      rd_reg;
    logic [11:0]     csr_addr_reg;
    logic            wen_reg, csr_wen_reg;
    logic            brch_reg, jal_reg, jalr_reg, mret_reg, ecall_reg;

    logic            rf_wen_reg, rf_wen_next;
    logic [4:0]      rf_waddr_reg, rf_waddr_next;
    logic [XLEN-1:0] rf_wdata_reg, rf_wdata_next;
    logic            csr_wen_reg_o, csr_wen_next;
    logic [11:0]     csr_waddr_reg, csr_waddr_next;
    logic [XLEN-1:0] csr_wdata_reg, csr_wdata_next;
    logic            redir_vld_reg, redir_vld_next;
    logic [XLEN-1:0] redir_pc_reg, redir_pc_next;
    logic            retire_reg, retire_next;
    logic [CNT_W-1:0] retire_cnt_reg;

    logic            accept;
    logic            retire;

    // Current instruction view: live inputs on the accept cycle, captured copy afterwards.
    logic [XLEN-1:0] c_pc, c_tgt, c_res, c_mepc, c_mtvec;
    logic [4:0]      c_rd;
    logic [11:0]     c_csr_addr;
    logic            c_wen, c_csr_wen, c_brch, c_jal, c_jalr, c_mret, c_ecall;
    logic            c_redir;
    logic [XLEN-1:0] c_target;

    assign accept = bus.i_valid && (state_reg == ST_IDLE);

    always_comb begin
        c_pc       = accept ? bus.i_pc       : pc_reg;
        c_tgt      = accept ? bus.i_pc_next  : tgt_reg;
        c_res      = accept ? bus.i_res      : res_reg;
        c_mepc     = accept ? bus.i_mepc     : mepc_reg;
        c_mtvec    = accept ? bus.i_mtvec    : mtvec_reg;
        c_rd       = accept ? bus.i_rd_addr  : rd_reg;
        c_csr_addr = accept ? bus.i_csr_addr : csr_addr_reg;
        c_wen      = accept ? bus.i_wen      : wen_reg;
        c_csr_wen  = accept ? bus.i_csr_wen  : csr_wen_reg;
        c_brch     = accept ? bus.i_brch     : brch_reg;
        c_jal      = accept ? bus.i_jal      : jal_reg;
        c_jalr     = accept ? bus.i_jalr     : jalr_reg;
        c_mret     = accept ? bus.i_mret     : mret_reg;
        c_ecall    = accept ? bus.i_ecall    : ecall_reg;
        c_redir    = is_redirect(c_brch, c_res[0], c_jal, c_jalr, c_mret);
        // ecall outranks mret, which outranks ordinary jumps/branches.
        c_target   = c_ecall ? c_mtvec : (c_mret ? c_mepc : c_tgt);
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:   if (accept) state_next = ST_COMMIT;
            ST_COMMIT: begin
                if (c_ecall)      state_next = ST_TRAP;
                else if (c_redir) state_next = ST_REDIR;
                else              state_next = ST_IDLE;
            end
            ST_TRAP:   state_next = ST_REDIR;
            ST_REDIR:  if (bus.i_redir_rdy) state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    // Output registers are loaded for the state being entered, so strobes line
    // up exactly with the COMMIT/TRAP/REDIR cycles.
    always_comb begin
        rf_wen_next    = 1'b0;
        rf_waddr_next  = '0;
        rf_wdata_next  = '0;
        csr_wen_next   = 1'b0;
        csr_waddr_next = '0;
        csr_wdata_next = '0;
        redir_vld_next = 1'b0;
        redir_pc_next  = '0;
        retire_next    = 1'b0;
        case (state_next)
            ST_COMMIT: begin
                rf_wen_next   = c_wen && (c_rd != 5'd0) && !c_brch;
                rf_waddr_next = c_rd;
                rf_wdata_next = (c_jal || c_jalr) ? c_pc + XLEN'(4) : c_res;
                if (c_ecall) begin
                    csr_wen_next   = 1'b1;
                    csr_waddr_next = CSR_MEPC;
                    csr_wdata_next = c_pc;
                end else begin
                    csr_wen_next   = c_csr_wen;
                    csr_waddr_next = c_csr_addr;
                    csr_wdata_next = c_res;
                end
                retire_next = !c_ecall && !c_redir;
            end
            ST_TRAP: begin
                csr_wen_next   = 1'b1;
                csr_waddr_next = CSR_MCAUSE;
                csr_wdata_next = MCAUSE_ECM;
            end
            ST_REDIR: begin
                redir_vld_next = 1'b1;
                redir_pc_next  = c_target;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg     <= ST_IDLE;
            rf_wen_reg    <= 1'b0;
            rf_waddr_reg  <= '0;
            rf_wdata_reg  <= '0;
            csr_wen_reg_o <= 1'b0;
            csr_waddr_reg <= '0;
            csr_wdata_reg <= '0;
            redir_vld_reg <= 1'b0;
            redir_pc_reg  <= '0;
            retire_reg    <= 1'b0;
        end else begin
            state_reg     <= state_next;
            rf_wen_reg    <= rf_wen_next;
            rf_waddr_reg  <= rf_waddr_next;
            rf_wdata_reg  <= rf_wdata_next;
            csr_wen_reg_o <= csr_wen_next;
            csr_waddr_reg <= csr_waddr_next;
            csr_wdata_reg <= csr_wdata_next;
            redir_vld_reg <= redir_vld_next;
            redir_pc_reg  <= redir_pc_next;
            retire_reg    <= retire_next;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc_reg       <= '0;
            tgt_reg      <= '0;
            res_reg      <= '0;
            mepc_reg     <= '0;
            mtvec_reg    <= '0;
            rd_reg       <= '0;
            csr_addr_reg <= '0;
            wen_reg      <= 1'b0;
            csr_wen_reg  <= 1'b0;
            brch_reg     <= 1'b0;
            jal_reg      <= 1'b0;
            jalr_reg     <= 1'b0;
            mret_reg     <= 1'b0;
            ecall_reg    <= 1'b0;
        end else if (accept) begin
            pc_reg       <= bus.i_pc;
            tgt_reg      <= bus.i_pc_next;
            res_reg      <= bus.i_res;
            mepc_reg     <= bus.i_mepc;
            mtvec_reg    <= bus.i_mtvec;
            rd_reg       <= bus.i_rd_addr;
            csr_addr_reg <= bus.i_csr_addr;
            wen_reg      <= bus.i_wen;
            csr_wen_reg  <= bus.i_csr_wen;
            brch_reg     <= bus.i_brch;
            jal_reg      <= bus.i_jal;
            jalr_reg     <= bus.i_jalr;
            mret_reg     <= bus.i_mret;
            ecall_reg    <= bus.i_ecall;
        end
    end

    // Redirecting instructions retire in the cycle the IFU takes the new PC.
    assign retire = retire_reg || (redir_vld_reg && bus.i_redir_rdy);

    always_ff @(posedge clock or posedge reset) begin
        if (reset)       retire_cnt_reg <= '0;
        else if (retire) retire_cnt_reg <= retire_cnt_reg + CNT_W'(1);
    end

    assign bus.o_ready      = (state_reg == ST_IDLE);
    assign bus.o_rf_wen     = rf_wen_reg;
    assign bus.o_rf_waddr   = rf_waddr_reg;
    assign bus.o_rf_wdata   = rf_wdata_reg;
    assign bus.o_csr_wen    = csr_wen_reg_o;
    assign bus.o_csr_waddr  = csr_waddr_reg;
    assign bus.o_csr_wdata  = csr_wdata_reg;
    assign bus.o_redir_vld  = redir_vld_reg;
    assign bus.o_redir_pc   = redir_pc_reg;
    assign bus.o_retire     = retire;
    assign bus.o_retire_cnt = retire_cnt_reg;

endmodule

// File: tb/tb_ysyx_23060124_wbu.sv
// Directed bench for the commit stage: plain writes, jumps, branches, ecall,
// mret, reset in REDIR and retire-counter wrap on a narrow-counter instance.
module tb_ysyx_23060124_wbu;

    logic clock;
    logic reset;
    int   checks;
    int   errors;

    ysyx_23060124_wbu_if #(.XLEN(32), .CNT_W(64)) bus ();
    ysyx_23060124_wbu_if #(.XLEN(32), .CNT_W(3))  bus_w ();

    ysyx_23060124_wbu #(.XLEN(32), .CNT_W(64)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    // Narrow counter so the all-ones -> 0 wrap is reachable in a few retires.
    ysyx_23060124_wbu #(.XLEN(32), .CNT_W(3)) dut_w (
        .clock (clock),
        .reset (reset),
        .bus   (bus_w)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clr_inputs();
        bus.i_valid = 0; bus.i_pc = 0; bus.i_pc_next = 0; bus.i_res = 0;
        bus.i_rd_addr = 0; bus.i_wen = 0; bus.i_csr_addr = 0; bus.i_csr_wen = 0;
        bus.i_brch = 0; bus.i_jal = 0; bus.i_jalr = 0; bus.i_mret = 0;
        bus.i_ecall = 0; bus.i_mepc = 0; bus.i_mtvec = 0; bus.i_redir_rdy = 0;
    endtask

    task automatic clr_inputs_w();
        bus_w.i_valid = 0; bus_w.i_pc = 0; bus_w.i_pc_next = 0; bus_w.i_res = 0;
        bus_w.i_rd_addr = 0; bus_w.i_wen = 0; bus_w.i_csr_addr = 0; bus_w.i_csr_wen = 0;
        bus_w.i_brch = 0; bus_w.i_jal = 0; bus_w.i_jalr = 0; bus_w.i_mret = 0;
        bus_w.i_ecall = 0; bus_w.i_mepc = 0; bus_w.i_mtvec = 0; bus_w.i_redir_rdy = 0;
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_ready"},  64'(bus.o_ready), 64'd1);
        check({tag, "_rfwen"},  64'(bus.o_rf_wen), 64'd0);
        check({tag, "_csrwen"}, 64'(bus.o_csr_wen), 64'd0);
        check({tag, "_redir"},  64'(bus.o_redir_vld), 64'd0);
        check({tag, "_retire"}, 64'(bus.o_retire), 64'd0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        clr_inputs();
        clr_inputs_w();
        #12;
        check_quiet("rst");
        check("rst_redir_pc", 64'(bus.o_redir_pc), 64'd0);
        check("rst_rf_wdata", 64'(bus.o_rf_wdata), 64'd0);
        check("rst_cnt", bus.o_retire_cnt, 64'd0);
        @(negedge clock);
        reset = 1'b0;
        tick();

        // addi x5, res 0x2A
        bus.i_valid = 1; bus.i_wen = 1; bus.i_rd_addr = 5; bus.i_res = 32'h2A;
        check("addi_ready", 64'(bus.o_ready), 64'd1);
        tick();
        clr_inputs();
        check("addi_rfwen",  64'(bus.o_rf_wen), 64'd1);
        check("addi_waddr",  64'(bus.o_rf_waddr), 64'd5);
        check("addi_wdata",  64'(bus.o_rf_wdata), 64'h2A);
        check("addi_retire", 64'(bus.o_retire), 64'd1);
        check("addi_ready0", 64'(bus.o_ready), 64'd0);
        check("addi_cnt0",   bus.o_retire_cnt, 64'd0);
        tick();
        check_quiet("addi_idle");
        check("addi_cnt1", bus.o_retire_cnt, 64'd1);
        $display("txn addi   cnt=%0d", bus.o_retire_cnt);

        // write to x0 is dropped but still retires
        bus.i_valid = 1; bus.i_wen = 1; bus.i_rd_addr = 0; bus.i_res = 32'h55;
        tick();
        clr_inputs();
        check("x0_rfwen",  64'(bus.o_rf_wen), 64'd0);
        check("x0_retire", 64'(bus.o_retire), 64'd1);
        tick();
        check("x0_cnt", bus.o_retire_cnt, 64'd2);
        $display("txn x0     cnt=%0d", bus.o_retire_cnt);

        // jal rd=1, held redirect for 3 cycles before the IFU accepts
        bus.i_valid = 1; bus.i_jal = 1; bus.i_wen = 1; bus.i_rd_addr = 1;
        bus.i_pc = 32'h8000_0000; bus.i_pc_next = 32'h8000_0100; bus.i_res = 32'h1234;
        tick();
        clr_inputs();
        check("jal_rfwen",  64'(bus.o_rf_wen), 64'd1);
        check("jal_waddr",  64'(bus.o_rf_waddr), 64'd1);
        check("jal_wdata",  64'(bus.o_rf_wdata), 64'h8000_0004);
        check("jal_retire0", 64'(bus.o_retire), 64'd0);
        check("jal_redir0", 64'(bus.o_redir_vld), 64'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("jal_hold_vld", 64'(bus.o_redir_vld), 64'd1);
            check("jal_hold_pc",  64'(bus.o_redir_pc), 64'h8000_0100);
            check("jal_hold_rdy", 64'(bus.o_ready), 64'd0);
            check("jal_hold_ret", 64'(bus.o_retire), 64'd0);
            check("jal_hold_rf",  64'(bus.o_rf_wen), 64'd0);
        end
        bus.i_redir_rdy = 1;
        #1;
        check("jal_ack_retire", 64'(bus.o_retire), 64'd1);
        tick();
        bus.i_redir_rdy = 0;
        check_quiet("jal_idle");
        check("jal_cnt", bus.o_retire_cnt, 64'd3);
        $display("txn jal    cnt=%0d", bus.o_retire_cnt);

        // beq not taken
        bus.i_valid = 1; bus.i_brch = 1; bus.i_res = 32'h0; bus.i_pc_next = 32'h8000_0200;
        tick();
        clr_inputs();
        check("bnt_rfwen",  64'(bus.o_rf_wen), 64'd0);
        check("bnt_retire", 64'(bus.o_retire), 64'd1);
        tick();
        check_quiet("bnt_idle");
        check("bnt_cnt", bus.o_retire_cnt, 64'd4);
        $display("txn bnt    cnt=%0d", bus.o_retire_cnt);

        // beq taken, IFU ready immediately: two-cycle commit
        bus.i_valid = 1; bus.i_brch = 1; bus.i_res = 32'h1; bus.i_pc_next = 32'h8000_0200;
        bus.i_redir_rdy = 1;
        tick();
        bus.i_valid = 0; bus.i_brch = 0;
        check("bt_retire0", 64'(bus.o_retire), 64'd0);
        check("bt_rfwen",   64'(bus.o_rf_wen), 64'd0);
        tick();
        check("bt_vld",    64'(bus.o_redir_vld), 64'd1);
        check("bt_pc",     64'(bus.o_redir_pc), 64'h8000_0200);
        check("bt_retire", 64'(bus.o_retire), 64'd1);
        tick();
        clr_inputs();
        #1;
        check_quiet("bt_idle");
        check("bt_cnt", bus.o_retire_cnt, 64'd5);
        $display("txn bt     cnt=%0d", bus.o_retire_cnt);

        // ecall: mepc write, mcause write, then redirect to mtvec
        bus.i_valid = 1; bus.i_ecall = 1; bus.i_pc = 32'h8000_0010;
        bus.i_mtvec = 32'h8000_1000; bus.i_mepc = 32'h8000_0777; bus.i_pc_next = 32'h8000_0BAD;
        tick();
        clr_inputs();
        check("ec_csrwen0", 64'(bus.o_csr_wen), 64'd1);
        check("ec_addr0",   64'(bus.o_csr_waddr), 64'h341);
        check("ec_data0",   64'(bus.o_csr_wdata), 64'h8000_0010);
        check("ec_ret0",    64'(bus.o_retire), 64'd0);
        tick();
        check("ec_csrwen1", 64'(bus.o_csr_wen), 64'd1);
        check("ec_addr1",   64'(bus.o_csr_waddr), 64'h342);
        check("ec_data1",   64'(bus.o_csr_wdata), 64'd11);
        check("ec_redir1",  64'(bus.o_redir_vld), 64'd0);
        tick();
        check("ec_csrwen2", 64'(bus.o_csr_wen), 64'd0);
        check("ec_vld",     64'(bus.o_redir_vld), 64'd1);
        check("ec_pc",      64'(bus.o_redir_pc), 64'h8000_1000);
        bus.i_redir_rdy = 1;
        #1;
        check("ec_retire", 64'(bus.o_retire), 64'd1);
        tick();
        bus.i_redir_rdy = 0;
        check_quiet("ec_idle");
        check("ec_cnt", bus.o_retire_cnt, 64'd6);
        $display("txn ecall  cnt=%0d", bus.o_retire_cnt);

        // plain CSR write
        bus.i_valid = 1; bus.i_csr_wen = 1; bus.i_csr_addr = 12'h300; bus.i_res = 32'h1888;
        tick();
        clr_inputs();
        check("csr_wen",    64'(bus.o_csr_wen), 64'd1);
        check("csr_addr",   64'(bus.o_csr_waddr), 64'h300);
        check("csr_data",   64'(bus.o_csr_wdata), 64'h1888);
        check("csr_retire", 64'(bus.o_retire), 64'd1);
        tick();
        check("csr_cnt", bus.o_retire_cnt, 64'd7);
        $display("txn csrw   cnt=%0d", bus.o_retire_cnt);

        // mret with jal also set: mepc wins over pc_next
        bus.i_valid = 1; bus.i_mret = 1; bus.i_jal = 1; bus.i_mepc = 32'h8000_0040;
        bus.i_pc_next = 32'h8000_0300; bus.i_mtvec = 32'h8000_1000;
        tick();
        clr_inputs();
        tick();
        check("mret_vld", 64'(bus.o_redir_vld), 64'd1);
        check("mret_pc",  64'(bus.o_redir_pc), 64'h8000_0040);
        bus.i_redir_rdy = 1;
        tick();
        bus.i_redir_rdy = 0;
        check("mret_cnt", bus.o_retire_cnt, 64'd8);
        $display("txn mret   cnt=%0d", bus.o_retire_cnt);

        // reset while holding a redirect
        bus.i_valid = 1; bus.i_jalr = 1; bus.i_pc_next = 32'h8000_0500;
        tick();
        clr_inputs();
        tick();
        check("rr_vld_pre", 64'(bus.o_redir_vld), 64'd1);
        reset = 1'b1;
        #1;
        check_quiet("rr");
        check("rr_pc",  64'(bus.o_redir_pc), 64'd0);
        check("rr_cnt", bus.o_retire_cnt, 64'd0);
        @(negedge clock);
        reset = 1'b0;
        tick();
        check("rr_after_vld", 64'(bus.o_redir_vld), 64'd0);
        $display("txn rstrd  cnt=%0d", bus.o_retire_cnt);

        // 3-bit counter: seven retires reach all-ones, the eighth wraps to 0
        for (int i = 1; i <= 8; i++) begin
            bus_w.i_valid = 1; bus_w.i_wen = 1; bus_w.i_rd_addr = 3; bus_w.i_res = 32'(i);
            tick();
            bus_w.i_valid = 0;
            check("wrap_retire", 64'(bus_w.o_retire), 64'd1);
            tick();
            check("wrap_cnt", 64'(bus_w.o_retire_cnt), 64'(i % 8));
        end
        $display("txn wrap   cnt=%0d", bus_w.o_retire_cnt);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Watchdog in case the stimulus stalls.
    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "timeout");
    end

endmodule
